// File: rtl/nonce_scheduler.sv
// -----------------------------------------------------------------------------
// nonce_scheduler
//   hash_clk-domain stage sitting directly behind the UART job receiver.
//   It captures a job on the new_work pulse and sweeps nonces from nonce_min
//   to nonce_max (inclusive) into a pipelined double-SHA256 core. It also
//   filters the core's results for hits and reports each hit back to the
//   receiver as golden_nonce, with new_golden_nonce toggling once per hit.
//
// Optional feature (compile-time macro GOLDEN_FIFO_EN):
//   defined   -> a 4-entry hit FIFO feeds the report path. A hit that
//                arrives while the FIFO is full is dropped and sets an
//                internal sticky overflow bit.
//   undefined -> a single pending slot. The newest hit seen during the hold
//                window wins. With no hold and nothing pending, a hit is
//                reported on the next cycle.
//
// Parameters:
//   ZERO_BITS    a result is a hit when the top ZERO_BITS bits of
//                res_hash_hi are zero (1..32)
//   OUT_W        width of the outstanding-result counter
//                (core depth < 2**OUT_W)
//   HOLD_CYCLES  minimum number of cycles between two report toggles
//
// Ports:
//   hash_clk, reset                     clock, async active-high reset
//   new_work, midstate, work_data,
//   nonce_min, nonce_max                job capture (new_work is a 1-cycle
//                                       pulse)
//   core_ready / core_valid, core_*     issue handshake towards the core
//   res_valid, res_nonce, res_tag,
//   res_hash_hi                         result stream from the core
//                                       (no backpressure)
//   golden_nonce, new_golden_nonce      hit report (toggle protocol)
//   busy, job_done                      job status
// -----------------------------------------------------------------------------
module nonce_scheduler #(
   parameter int ZERO_BITS   = 32,
   parameter int OUT_W       = 8,
   parameter int HOLD_CYCLES = 8
) (
   input  logic         hash_clk,
   input  logic         reset,
   input  logic         new_work,
   input  logic [255:0] midstate,
   input  logic [95:0]  work_data,
   input  logic [31:0]  nonce_min,
   input  logic [31:0]  nonce_max,
   input  logic         core_ready,
   output logic         core_valid,
   output logic [255:0] core_midstate,
   output logic [95:0]  core_data,
   output logic [31:0]  core_nonce,
   output logic [1:0]   core_tag,
   input  logic         res_valid,
   input  logic [31:0]  res_nonce,
   input  logic [1:0]   res_tag,
   input  logic [31:0]  res_hash_hi,
   output logic [31:0]  golden_nonce,
   output logic         new_golden_nonce,
   output logic         busy,
   output logic         job_done
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_r;
   logic [1:0]         tag_r;
   logic [31:0]        nonce_r;
   logic [31:0]        max_r;
   logic [255:0]       midstate_r;
   logic [95:0]        data_r;
   logic [OUT_W-1:0]   outstanding_r;
   logic [OUT_W-1:0]   outstanding_next_s;
   logic [HOLD_W-1:0]  hold_r;
   logic [31:0]        golden_r;
   logic               toggle_r;
   logic               job_done_r;

   logic               issue_s;
   logic               match_s;
   logic               hit_s;
   logic               report_s;
   logic [31:0]        report_nonce_s;

   assign core_valid       = (state_r == RUN);
   assign core_midstate    = midstate_r;
   assign core_data        = data_r;
   assign core_nonce       = nonce_r;
   assign core_tag         = tag_r;
   assign golden_nonce     = golden_r;
   assign new_golden_nonce = toggle_r;
   assign busy             = (state_r == RUN) || (state_r == DRAIN);
   assign job_done         = job_done_r;

   // Issue/result qualification and the next outstanding-result count
   always_comb begin
      issue_s            = (state_r == RUN) && core_ready;
      match_s            = res_valid && (res_tag == tag_r);
      hit_s              = match_s && (res_hash_hi[31 -: ZERO_BITS] == '0);
      outstanding_next_s = outstanding_r;
      if (issue_s && !match_s) begin
         outstanding_next_s = outstanding_r + OUT_W'(1);
      end else if (!issue_s && match_s && (outstanding_r != '0)) begin
         // The non-zero guard keeps a stray matching result from wrapping the count
         outstanding_next_s = outstanding_r - OUT_W'(1);
      end else begin
         outstanding_next_s = outstanding_r;
      end
   end

   // Job FSM: capture, sweep, drain, and completion pulse
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         tag_r         <= 2'd0;
         nonce_r       <= 32'd0;
         max_r         <= 32'd0;
         midstate_r    <= 256'd0;
         data_r        <= 96'd0;
         outstanding_r <= '0;
         job_done_r    <= 1'b0;
      end else begin
         job_done_r <= 1'b0;
         if (new_work) begin
            // Abort takes effect immediately. The new tag makes the old job's
            // in-flight results unmatched from now on.
            tag_r         <= tag_r + 2'd1;
            midstate_r    <= midstate;
            data_r        <= work_data;
            nonce_r       <= nonce_min;
            max_r         <= nonce_max;
            outstanding_r <= '0;
            state_r       <= (nonce_min > nonce_max) ? DRAIN : RUN;
         end else begin
            outstanding_r <= outstanding_next_s;
            case (state_r)
               IDLE: state_r <= IDLE;
               RUN: begin
                  if (issue_s) begin
                     // The end test comes before the increment, so max = FFFFFFFF never wraps
                     if (nonce_r == max_r) begin
                        state_r <= DRAIN;
                     end else begin
                        nonce_r <= nonce_r + 32'd1;
                     end
                  end
               end
               DRAIN: begin
                  if (outstanding_next_s == '0) begin
                     state_r    <= DONE;
                     job_done_r <= 1'b1;
                  end
               end
               DONE:    state_r <= DONE;
               default: state_r <= IDLE;
            endcase
         end
      end
   end

`ifdef GOLDEN_FIFO_EN
   logic [31:0] fifo_r [4];
   logic [1:0]  wr_ptr_r;
   logic [1:0]  rd_ptr_r;
   logic [2:0]  count_r;
   logic        overflow_r;
   logic        push_s;

   // Pop one buffered hit per report. A push into a full FIFO is allowed when it pops in the same cycle.
   always_comb begin
      report_s       = (hold_r == '0) && (count_r != 3'd0);
      report_nonce_s = 32'd0;
      if (report_s) begin
         report_nonce_s = fifo_r[rd_ptr_r];
      end else begin
         report_nonce_s = 32'd0;
      end
      push_s = hit_s && ((count_r != 3'd4) || report_s);
   end

   // Hit FIFO storage, pointers, occupancy and sticky overflow
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            fifo_r[i] <= 32'd0;
         end
         wr_ptr_r   <= 2'd0;
         rd_ptr_r   <= 2'd0;
         count_r    <= 3'd0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            fifo_r[wr_ptr_r] <= res_nonce;
            wr_ptr_r         <= wr_ptr_r + 2'd1;
         end
         if (report_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         case ({push_s, report_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
         overflow_r <= overflow_r | (hit_s & ~push_s);
      end
   end
`else
   logic        pend_valid_r;
   logic [31:0] pend_nonce_r;
   logic        store_s;

   // A pending hit goes out first. A fresh hit is reported directly only when nothing is waiting.
   always_comb begin
      report_s       = 1'b0;
      report_nonce_s = 32'd0;
      if (hold_r != '0) begin
         report_s = 1'b0;
      end else if (pend_valid_r) begin
         report_s       = 1'b1;
         report_nonce_s = pend_nonce_r;
      end else if (hit_s) begin
         report_s       = 1'b1;
         report_nonce_s = res_nonce;
      end else begin
         report_s = 1'b0;
      end
      store_s = hit_s && ((hold_r != '0) || pend_valid_r);
   end

   // Single pending slot: the newest hit overwrites it
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         pend_valid_r <= 1'b0;
         pend_nonce_r <= 32'd0;
      end else if (store_s) begin
         pend_valid_r <= 1'b1;
         pend_nonce_r <= res_nonce;
      end else if (report_s) begin
         pend_valid_r <= 1'b0;
      end else begin
         pend_valid_r <= pend_valid_r;
      end
   end
`endif

   // Report register: latch golden nonce, toggle, and run the hold countdown
   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         golden_r <= 32'd0;
         toggle_r <= 1'b0;
         hold_r   <= '0;
      end else if (report_s) begin
         golden_r <= report_nonce_s;
         toggle_r <= ~toggle_r;
         hold_r   <= HOLD_W'(HOLD_CYCLES);
      end else if (hold_r != '0) begin
         hold_r <= hold_r - HOLD_W'(1);
      end else begin
         hold_r <= hold_r;
      end
   end

endmodule

// File: tb/tb_nonce_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nonce_scheduler
//   Drives directed and randomized jobs into nonce_scheduler. A simple core
//   model echoes each issue back as a result after a fixed latency.
//   Expectations come from the job rules: the nonce sequence, the tag, drain
//   completion, hit filtering by tag and report spacing.
// -----------------------------------------------------------------------------
module tb_nonce_scheduler;

   localparam int HOLD = 8;

   logic         hash_clk;
   logic         reset;
   logic         new_work;
   logic [255:0] midstate;
   logic [95:0]  work_data;
   logic [31:0]  nonce_min;
   logic [31:0]  nonce_max;
   logic         core_ready;
   logic         core_valid;
   logic [255:0] core_midstate;
   logic [95:0]  core_data;
   logic [31:0]  core_nonce;
   logic [1:0]   core_tag;
   logic         res_valid;
   logic [31:0]  res_nonce;
   logic [1:0]   res_tag;
   logic [31:0]  res_hash_hi;
   logic [31:0]  golden_nonce;
   logic         new_golden_nonce;
   logic         busy;
   logic         job_done;

   nonce_scheduler dut (
      .hash_clk         (hash_clk),
      .reset            (reset),
      .new_work         (new_work),
      .midstate         (midstate),
      .work_data        (work_data),
      .nonce_min        (nonce_min),
      .nonce_max        (nonce_max),
      .core_ready       (core_ready),
      .core_valid       (core_valid),
      .core_midstate    (core_midstate),
      .core_data        (core_data),
      .core_nonce       (core_nonce),
      .core_tag         (core_tag),
      .res_valid        (res_valid),
      .res_nonce        (res_nonce),
      .res_tag          (res_tag),
      .res_hash_hi      (res_hash_hi),
      .golden_nonce     (golden_nonce),
      .new_golden_nonce (new_golden_nonce),
      .busy             (busy),
      .job_done         (job_done)
   );

   initial hash_clk = 1'b0;
   always #5 hash_clk = ~hash_clk;

   typedef struct {
      logic [31:0] nonce;
      logic [1:0]  tag;
      int          due;
      bit          hit;
   } res_t;

   res_t        pipe_q[$];
   logic [31:0] hit_list[$];
   logic [31:0] exp_hits[$];
   logic [31:0] rep_q[$];

   int          checks, errors, cyc, lat, last_tog_cyc, last_hit_cyc;
   int          done_pulses, issue_count;
   bit          auto_res, hit_all, rand_hits, rand_ready;
   logic [1:0]  exp_tag;
   logic [31:0] exp_next;
   longint      remaining;
   logic        prev_tog;
   logic [31:0] prev_golden;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic bit in_hit_list(input logic [31:0] n);
      foreach (hit_list[i]) if (hit_list[i] == n) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] rq(input int i);
      if (rep_q.size() > i) return rep_q[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic clear_model();
      pipe_q.delete();
      exp_tag      = 2'd0;
      exp_next     = 32'd0;
      remaining    = 0;
      prev_tog     = 1'b0;
      prev_golden  = 32'd0;
      last_tog_cyc = -1;
      issue_count  = 0;
      done_pulses  = 0;
   endtask

   // One clock: account for the issue at this edge, present a due result, then observe the DUT
   task automatic step();
      res_t r;
      int   live;
      if (rand_ready) core_ready = ($urandom_range(3, 0) != 0);
      if (core_valid && core_ready && !new_work) begin
         chk("issue_tag", core_tag, exp_tag);
         chk("issue_nonce", core_nonce, exp_next);
         chk("issue_in_range", remaining > 0, 1'b1);
         exp_next = exp_next + 32'd1;
         if (remaining > 0) remaining--;
         issue_count++;
         if (auto_res) begin
            r.nonce = core_nonce;
            r.tag   = core_tag;
            r.due   = cyc + lat;
            r.hit   = hit_all || in_hit_list(core_nonce);
            if (rand_hits && (cyc - last_hit_cyc >= 12) && ($urandom_range(3, 0) == 0)) begin
               r.hit        = 1'b1;
               last_hit_cyc = cyc;
            end
            pipe_q.push_back(r);
         end
      end
      res_valid   = 1'b0;
      res_nonce   = 32'd0;
      res_tag     = 2'd0;
      res_hash_hi = 32'd0;
      if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
         r           = pipe_q.pop_front();
         res_valid   = 1'b1;
         res_nonce   = r.nonce;
         res_tag     = r.tag;
         res_hash_hi = r.hit ? 32'h0000_0000 : (32'h8000_0000 | $urandom);
         if (r.hit && r.tag == exp_tag) exp_hits.push_back(r.nonce);
      end
      @(posedge hash_clk);
      #1;
      cyc++;
      if (new_golden_nonce !== prev_tog) begin
         if (last_tog_cyc >= 0) chk("hold_gap", (cyc - last_tog_cyc) >= HOLD, 1'b1);
         rep_q.push_back(golden_nonce);
         last_tog_cyc = cyc;
         prev_tog     = new_golden_nonce;
         prev_golden  = golden_nonce;
      end else begin
         chk("golden_stable", golden_nonce, prev_golden);
      end
      if (job_done) begin
         done_pulses++;
         live = 0;
         foreach (pipe_q[i]) if (pipe_q[i].tag == exp_tag) live++;
         chk("done_all_issued", remaining == 0, 1'b1);
         chk("done_after_results", live, 0);
         chk("done_not_busy", busy, 1'b0);
      end
   endtask

   task automatic start_job(input logic [31:0] mn, input logic [31:0] mx);
      logic [255:0] ms;
      logic [95:0]  wd;
      for (int k = 0; k < 8; k++) ms[k*32 +: 32] = $urandom;
      for (int k = 0; k < 3; k++) wd[k*32 +: 32] = $urandom;
      new_work  = 1'b1;
      nonce_min = mn;
      nonce_max = mx;
      midstate  = ms;
      work_data = wd;
      step();
      new_work    = 1'b0;
      exp_tag     = exp_tag + 2'd1;
      exp_next    = mn;
      remaining   = (mn > mx) ? 0 : (longint'(mx) - longint'(mn) + 1);
      issue_count = 0;
      done_pulses = 0;
      chk("job_midstate", core_midstate, ms);
      chk("job_data", core_data, wd);
   endtask

   task automatic wait_done(input int budget, input string name);
      int start_p;
      int n;
      start_p = done_pulses;
      n = 0;
      while (done_pulses == start_p && n < budget) begin
         step();
         n++;
      end
      chk(name, done_pulses != start_p, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      new_work = 1'b0;
      core_ready = 1'b0;
      res_valid = 1'b0;
      res_nonce = 32'd0;
      res_tag = 2'd0;
      res_hash_hi = 32'd0;
      repeat (2) @(posedge hash_clk);
      #1;
      reset = 1'b0;
      clear_model();
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_core_valid"}, core_valid, 1'b0);
      chk({pfx, "_core_nonce"}, core_nonce, 32'd0);
      chk({pfx, "_core_tag"}, core_tag, 2'd0);
      chk({pfx, "_core_midstate"}, core_midstate, 256'd0);
      chk({pfx, "_core_data"}, core_data, 96'd0);
      chk({pfx, "_golden"}, golden_nonce, 32'd0);
      chk({pfx, "_toggle"}, new_golden_nonce, 1'b0);
      chk({pfx, "_busy"}, busy, 1'b0);
      chk({pfx, "_job_done"}, job_done, 1'b0);
   endtask

   initial begin
      logic [31:0] mn, mx;
      int          k;
      checks = 0; errors = 0; cyc = 0; lat = 2; last_hit_cyc = -1000;
      auto_res = 1'b0; hit_all = 1'b0; rand_hits = 1'b0; rand_ready = 1'b0;
      midstate = 256'd0; work_data = 96'd0; nonce_min = 32'd0; nonce_max = 32'd0;
      clear_model();
      do_reset();
      chk_all_zero("reset");

      // Sweep 10..13 with every cycle ready; one hit on nonce 12
      auto_res = 1'b1; lat = 2; core_ready = 1'b1;
      hit_list.push_back(32'd12);
      start_job(32'd10, 32'd13);
      chk("t1_tag", core_tag, 2'd1);
      repeat (4) step();
      chk("t1_issue_count", issue_count, 4);
      chk("t1_drain_busy", busy, 1'b1);
      chk("t1_drain_no_valid", core_valid, 1'b0);
      wait_done(50, "t2_done");
      repeat (12) step();
      chk("t2_toggles", rep_q.size(), 1);
      chk("t2_golden", golden_nonce, 32'd12);
      chk("t2_done_once", done_pulses, 1);

      // Abort mid-sweep: the late hit from the old tag must be ignored
      do_reset();
      rep_q.delete();
      hit_list.delete();
      hit_list.push_back(32'd5);
      lat = 6; core_ready = 1'b1;
      start_job(32'd0, 32'h0000_00FF);
      repeat (8) step();
      chk("t3_partial", issue_count, 8);
      start_job(32'd100, 32'd200);
      chk("t3_new_nonce", core_nonce, 32'd100);
      chk("t3_new_tag", core_tag, 2'd2);
      wait_done(400, "t3_done");
      chk("t3_issues", issue_count, 101);
      repeat (10) step();
      chk("t3_no_report", rep_q.size(), 0);
      chk("t3_toggle_level", new_golden_nonce, 1'b0);

      // Top-of-range sweep must not wrap; an empty range completes straight away
      hit_list.delete();
      lat = 2;
      start_job(32'hFFFF_FFFE, 32'hFFFF_FFFF);
      wait_done(50, "t4_wrap_done");
      chk("t4_wrap_issues", issue_count, 2);
      repeat (5) step();
      chk("t4_no_wrap", issue_count, 2);
      chk("t4_idle_valid", core_valid, 1'b0);
      start_job(32'd5, 32'd4);
      chk("t4_empty_busy", busy, 1'b1);
      chk("t4_empty_valid", core_valid, 1'b0);
      step();
      chk("t4_empty_done", job_done, 1'b1);
      step();
      chk("t4_done_pulse", job_done, 1'b0);
      chk("t4_empty_idle", busy, 1'b0);
      chk("t4_empty_issues", issue_count, 0);

      // Three hits on consecutive cycles
      repeat (20) step();
      rep_q.delete();
      hit_all = 1'b1; lat = 3;
      start_job(32'd20, 32'd22);
      wait_done(50, "t5_done");
      hit_all = 1'b0;
      repeat (40) step();
`ifdef GOLDEN_FIFO_EN
      chk("t5_report_count", rep_q.size(), 3);
      chk("t5_report0", rq(0), 32'd20);
      chk("t5_report1", rq(1), 32'd21);
      chk("t5_report2", rq(2), 32'd22);
`else
      chk("t5_report_count", rep_q.size(), 2);
      chk("t5_report0", rq(0), 32'd20);
      chk("t5_report1", rq(1), 32'd22);
`endif

      // Backpressure holds the issue fields, then an async reset mid-RUN
      lat = 4;
      start_job(32'd1000, 32'd2000);
      repeat (3) step();
      core_ready = 1'b0;
      repeat (5) begin
         step();
         chk("t6_hold_nonce", core_nonce, exp_next);
         chk("t6_hold_tag", core_tag, exp_tag);
         chk("t6_hold_valid", core_valid, 1'b1);
      end
      core_ready = 1'b1;
      repeat (3) step();
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("t6_async");
      @(posedge hash_clk);
      #1;
      reset = 1'b0;
      clear_model();

      // Randomized jobs, random ready, sparse random hits, occasional abort
      rep_q.delete(); exp_hits.delete(); hit_list.delete();
      auto_res = 1'b1; lat = 4; rand_ready = 1'b1; rand_hits = 1'b1;
      last_hit_cyc = cyc - 100;
      for (int j = 0; j < 14; j++) begin
         mn = $urandom_range(32'hFFFF_0000, 32'd1);
         if ($urandom_range(5, 0) == 0) mx = mn - 32'd1;
         else mx = mn + $urandom_range(24, 0);
         start_job(mn, mx);
         if (j < 13 && $urandom_range(3, 0) == 0) begin
            k = $urandom_range(8, 0);
            repeat (k) step();
         end else begin
            wait_done(400, "rand_done");
         end
      end
      rand_hits = 1'b0; rand_ready = 1'b0; core_ready = 1'b1;
      repeat (40) step();
      chk("rand_hit_count", rep_q.size(), exp_hits.size());
      foreach (exp_hits[i]) chk("rand_hit_nonce", rq(i), exp_hits[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
